// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, shift selects, FSM states
// and the registered operation bundle driven onto the ALU.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_FWD   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] op;
    logic [1:0] shift_sel;
    logic [7:0] shift_val;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Combinational two-way round-robin grant; rr_ptr picks the winner only
// when both requesters are valid.
module rr_grant2 (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  input  logic enable,
  output logic grant_valid,
  output logic grant_idx
);

  always_comb begin
    grant_valid = enable && (valid0 || valid1);
    grant_idx   = (valid0 && valid1) ? rr_ptr : valid1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: round-robin accept,
// registered ALU operands, fixed settle wait, one-cycle response pulse.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0_VALID,
  output logic       REQ0_READY,
  input  logic [7:0] REQ0_DATA1,
  input  logic [7:0] REQ0_DATA2,
  input  logic [2:0] REQ0_OP,
  input  logic [1:0] REQ0_SHIFT_SEL,
  input  logic [7:0] REQ0_SHIFT_VAL,
  output logic       RESP0_VALID,
  output logic [7:0] RESP0_RESULT,
  output logic       RESP0_ZERO,
  input  logic       REQ1_VALID,
  output logic       REQ1_READY,
  input  logic [7:0] REQ1_DATA1,
  input  logic [7:0] REQ1_DATA2,
  input  logic [2:0] REQ1_OP,
  input  logic [1:0] REQ1_SHIFT_SEL,
  input  logic [7:0] REQ1_SHIFT_VAL,
  output logic       RESP1_VALID,
  output logic [7:0] RESP1_RESULT,
  output logic       RESP1_ZERO,
  output logic [7:0] ALU_DATA1,
  output logic [7:0] ALU_DATA2,
  output logic [2:0] ALU_SELECT,
  output logic [1:0] ALU_SHIFT_SELECT,
  output logic [7:0] ALU_SHIFT_VALUE,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_ZERO,
  output logic       BUSY
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  alu_req_t          alu_q, alu_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [1:0][7:0]   resp_result_q, resp_result_d;
  logic [1:0]        resp_zero_q, resp_zero_d;

  logic              grant_valid;
  logic              grant_idx;
  alu_req_t          req0, req1;

  assign req0 = '{data1: REQ0_DATA1, data2: REQ0_DATA2, op: REQ0_OP,
                  shift_sel: REQ0_SHIFT_SEL, shift_val: REQ0_SHIFT_VAL};
  assign req1 = '{data1: REQ1_DATA1, data2: REQ1_DATA2, op: REQ1_OP,
                  shift_sel: REQ1_SHIFT_SEL, shift_val: REQ1_SHIFT_VAL};

  rr_grant2 u_grant (
    .valid0      (REQ0_VALID),
    .valid1      (REQ1_VALID),
    .rr_ptr      (rr_ptr_q),
    .enable      (state_q == ST_IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      alu_q         <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_zero_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      alu_q         <= alu_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_zero_q   <= resp_zero_d;
    end
  end

  // The DONE step is folded into the counter==0 edge of WAIT, returning
  // straight to IDLE while the response registers load.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    alu_d         = alu_q;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    resp_zero_d   = resp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d  = ST_WAIT;
          cnt_d    = CNT_W'(LATENCY - 1);
          owner_d  = grant_idx;
          rr_ptr_d = ~grant_idx;
          alu_d    = grant_idx ? req1 : req0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d                = ST_IDLE;
          resp_valid_d[owner_q]  = 1'b1;
          resp_result_d[owner_q] = ALU_RESULT;
          // The ALU only refreshes ZERO on ADD, so any other op reports 0.
          resp_zero_d[owner_q]   = (alu_q.op == OP_ADD) && ALU_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state_q != ST_IDLE);
    REQ0_READY = grant_valid && !grant_idx;
    REQ1_READY = grant_valid && grant_idx;
  end

  assign ALU_DATA1        = alu_q.data1;
  assign ALU_DATA2        = alu_q.data2;
  assign ALU_SELECT       = alu_q.op;
  assign ALU_SHIFT_SELECT = alu_q.shift_sel;
  assign ALU_SHIFT_VALUE  = alu_q.shift_val;

  assign RESP0_VALID  = resp_valid_q[0];
  assign RESP0_RESULT = resp_result_q[0];
  assign RESP0_ZERO   = resp_zero_q[0];
  assign RESP1_VALID  = resp_valid_q[1];
  assign RESP1_RESULT = resp_result_q[1];
  assign RESP1_ZERO   = resp_zero_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the ALU_* side, directed vectors,
// multi-cycle corner sequences and a randomized run against a transaction model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid [2];
  logic [7:0] req_d1 [2];
  logic [7:0] req_d2 [2];
  logic [2:0] req_op [2];
  logic [1:0] req_ss [2];
  logic [7:0] req_sv [2];
  logic       ready0, ready1, resp0_valid, resp1_valid, resp0_zero, resp1_zero, busy;
  logic [7:0] resp0_result, resp1_result;
  logic [7:0] alu_d1, alu_d2, alu_sv, alu_result;
  logic [2:0] alu_sel;
  logic [1:0] alu_ss;
  logic       alu_zero;

  int checks = 0;
  int failures = 0;
  logic [7:0] held_res [2];
  logic       held_zero [2];

  always #5 clk = ~clk;

  alu_arbiter #(.LATENCY(LAT), .CNT_W(4)) dut (
    .CLK(clk), .RESET(rst),
    .REQ0_VALID(req_valid[0]), .REQ0_READY(ready0), .REQ0_DATA1(req_d1[0]),
    .REQ0_DATA2(req_d2[0]), .REQ0_OP(req_op[0]), .REQ0_SHIFT_SEL(req_ss[0]),
    .REQ0_SHIFT_VAL(req_sv[0]), .RESP0_VALID(resp0_valid), .RESP0_RESULT(resp0_result),
    .RESP0_ZERO(resp0_zero),
    .REQ1_VALID(req_valid[1]), .REQ1_READY(ready1), .REQ1_DATA1(req_d1[1]),
    .REQ1_DATA2(req_d2[1]), .REQ1_OP(req_op[1]), .REQ1_SHIFT_SEL(req_ss[1]),
    .REQ1_SHIFT_VAL(req_sv[1]), .RESP1_VALID(resp1_valid), .RESP1_RESULT(resp1_result),
    .RESP1_ZERO(resp1_zero),
    .ALU_DATA1(alu_d1), .ALU_DATA2(alu_d2), .ALU_SELECT(alu_sel),
    .ALU_SHIFT_SELECT(alu_ss), .ALU_SHIFT_VALUE(alu_sv),
    .ALU_RESULT(alu_result), .ALU_ZERO(alu_zero), .BUSY(busy)
  );

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [1:0] ss,
                                           input logic [7:0] sv);
    int ia, ib, r, k;
    ia = int'(a);
    ib = int'(b);
    k  = int'(sv);
    r  = 0;
    case (op)
      OP_FWD: r = ia;
      OP_ADD: r = ia + ib;
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_MUL: r = ia * ib;
      OP_SHIFT: begin
        case (ss)
          SH_SRL: r = (k >= 8) ? 0 : ia / (1 << k);
          SH_SLL: r = (k >= 8) ? 0 : ia * (1 << k);
          SH_SRA: begin
            if (ia >= 128) ia = ia - 256;
            if (k > 7) k = 7;
            r = ia >>> k;
          end
          default: begin
            k = k % 8;
            r = (ia >> k) | (ia << (8 - k));
          end
        endcase
      end
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // The external ALU raises ZERO for any zero result; masking non-ADD is the arbiter's job.
  always_comb begin
    alu_result = alu_model(alu_sel, alu_d1, alu_d2, alu_ss, alu_sv);
    alu_zero   = (alu_result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [1:0] ss, input logic [7:0] sv);
    req_valid[p] = 1'b1;
    req_op[p] = op;
    req_d1[p] = d1;
    req_d2[p] = d2;
    req_ss[p] = ss;
    req_sv[p] = sv;
  endtask

  task automatic drop_req(input int p);
    req_valid[p] = 1'b0;
    req_op[p] = $urandom_range(0, 7);
    req_d1[p] = $urandom_range(0, 255);
    req_d2[p] = $urandom_range(0, 255);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drop_req(0);
    drop_req(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    held_res[0] = '0;
    held_res[1] = '0;
    held_zero[0] = 1'b0;
    held_zero[1] = 1'b0;
  endtask

  typedef struct {
    int         port;
    logic [2:0] op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] ss;
    logic [7:0] sv;
    logic [7:0] res;
    logic       zero;
  } vec_t;

  vec_t vecs [11];

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int o;
    o = 1 - v.port;
    @(negedge clk);
    set_req(v.port, v.op, v.d1, v.d2, v.ss, v.sv);
    #1;
    chk($sformatf("vec%0d_ready", idx), (v.port == 1) ? ready1 : ready0, 1);
    chk($sformatf("vec%0d_ready_other", idx), (v.port == 1) ? ready0 : ready1, 0);
    @(negedge clk);
    drop_req(v.port);
    lat = 1;
    while (!((v.port == 1) ? resp1_valid : resp0_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, LAT + 1);
    chk($sformatf("vec%0d_result", idx), (v.port == 1) ? resp1_result : resp0_result, v.res);
    chk($sformatf("vec%0d_zero", idx), (v.port == 1) ? resp1_zero : resp0_zero, v.zero);
    chk($sformatf("vec%0d_other_valid", idx), (o == 1) ? resp1_valid : resp0_valid, 0);
    chk($sformatf("vec%0d_other_result", idx), (o == 1) ? resp1_result : resp0_result, held_res[o]);
    held_res[v.port] = v.res;
    held_zero[v.port] = v.zero;
    @(negedge clk);
    chk($sformatf("vec%0d_pulse_end", idx), (v.port == 1) ? resp1_valid : resp0_valid, 0);
    chk($sformatf("vec%0d_result_hold", idx), (v.port == 1) ? resp1_result : resp0_result, v.res);
  endtask

  // Transaction-level reference for the random phase.
  int         m_busy;
  int         m_owner;
  int         m_pref;
  logic [7:0] m_fres;
  logic       m_fzero;
  logic [7:0] m_f_d1, m_f_d2, m_f_sv;
  logic [2:0] m_f_op;
  logic [1:0] m_f_ss;

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int rports[$];
    int rvals[$];
    int waits;
    bit got0;
    bit pend[2];
    bit acc[2];
    logic [1:0] exp_rv;
    bit idle, e_r0, e_r1;

    vecs[0]  = '{0, OP_ADD,   8'd20,  8'd15,  SH_SRL, 8'd0, 8'd35,  1'b0};
    vecs[1]  = '{1, OP_ADD,   8'h05,  8'hFB,  SH_SRL, 8'd0, 8'h00,  1'b1};
    vecs[2]  = '{1, OP_FWD,   8'h00,  8'h33,  SH_SRL, 8'd0, 8'h00,  1'b0};
    vecs[3]  = '{1, OP_SHIFT, 8'h80,  8'h00,  SH_SRA, 8'd3, 8'hF0,  1'b0};
    vecs[4]  = '{1, OP_SHIFT, 8'h01,  8'h00,  SH_ROR, 8'd1, 8'h80,  1'b0};
    vecs[5]  = '{0, 3'b111,   8'h5A,  8'hA5,  SH_SLL, 8'd2, 8'h00,  1'b0};
    vecs[6]  = '{0, OP_MUL,   8'd3,   8'd5,   SH_SRL, 8'd0, 8'd15,  1'b0};
    vecs[7]  = '{0, OP_OR,    8'h0F,  8'hA0,  SH_SRL, 8'd0, 8'hAF,  1'b0};
    vecs[8]  = '{0, OP_SHIFT, 8'h81,  8'h00,  SH_SLL, 8'd1, 8'h02,  1'b0};
    vecs[9]  = '{1, OP_AND,   8'h32,  8'h25,  SH_SRL, 8'd0, 8'h20,  1'b0};
    vecs[10] = '{0, OP_SHIFT, 8'h81,  8'h00,  SH_SRL, 8'd4, 8'h08,  1'b0};

    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0;
      req_op[p] = '0;
      req_d1[p] = '0;
      req_d2[p] = '0;
      req_ss[p] = '0;
      req_sv[p] = '0;
      held_res[p] = '0;
      held_zero[p] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_alu", {alu_d1, alu_d2, alu_sel, alu_ss, alu_sv}, 0);
    chk("rst_resp", {resp0_valid, resp0_result, resp0_zero, resp1_valid, resp1_result, resp1_zero}, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of WAIT drops the operation silently.
    @(negedge clk);
    set_req(0, OP_ADD, 8'd1, 8'd1, SH_SRL, 8'd0);
    #1;
    chk("arst_accept", ready0, 1);
    @(negedge clk);
    drop_req(0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_alu", {alu_d1, alu_d2, alu_sel, alu_ss, alu_sv}, 0);
    chk("arst_resp0", {resp0_valid, resp0_result, resp0_zero}, 0);
    chk("arst_resp1", {resp1_valid, resp1_result, resp1_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_pulse", {resp0_valid, resp1_valid}, 0);
    end

    // Both requesters continuously valid: port 0 first after reset, then alternate.
    @(negedge clk);
    set_req(0, OP_MUL, 8'd3, 8'd5, SH_SRL, 8'd0);
    set_req(1, OP_AND, 8'h32, 8'h25, SH_SRL, 8'd0);
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (resp0_valid) begin rports.push_back(0); rvals.push_back(int'(resp0_result)); end
      if (resp1_valid) begin rports.push_back(1); rvals.push_back(int'(resp1_result)); end
      if (grants.size() >= 4) begin
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
      end
      if (grants.size() >= 4 && rports.size() >= 4) break;
      #1;
      if (ready0 && ready1) chk("fair_both_ready", {ready0, ready1}, 2'b00);
      if (ready0) grants.push_back(0);
      if (ready1) grants.push_back(1);
    end
    chk("fair_grant_count", grants.size(), 4);
    chk("fair_resp_count", rports.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk($sformatf("fair_grant%0d", i), grants[i], i % 2);
      if (i < rports.size()) begin
        chk($sformatf("fair_resp_port%0d", i), rports[i], i % 2);
        chk($sformatf("fair_resp_val%0d", i), rvals[i], (i % 2 == 0) ? 15 : 32'h20);
      end
    end

    // Reserved opcode on port 0; port 1 raised during WAIT must wait for IDLE.
    @(negedge clk);
    set_req(0, 3'b111, 8'h55, 8'h66, SH_SRL, 8'd0);
    #1;
    chk("rsv_ready0", ready0, 1);
    @(negedge clk);
    drop_req(0);
    set_req(1, OP_ADD, 8'h10, 8'h01, SH_SRL, 8'd0);
    waits = 0;
    got0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (resp0_valid) begin
        got0 = 1'b1;
        chk("rsv_result", resp0_result, 0);
        chk("rsv_zero", resp0_zero, 0);
      end
      #1;
      if (ready1) break;
      chk("wait_ready1_low", ready1, 0);
      waits++;
    end
    chk("wait_cycles", waits, LAT);
    chk("rsv_resp_seen", got0, 1);
    @(negedge clk);
    drop_req(1);
    waits = 1;
    while (!resp1_valid && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("wait_p1_latency", waits, LAT + 1);
    chk("wait_p1_result", resp1_result, 8'h11);
    chk("wait_p1_zero", resp1_zero, 0);

    // Randomized run against the transaction model.
    do_reset();
    m_busy = 0;
    m_owner = 0;
    m_pref = 0;
    m_fres = '0;
    m_fzero = 1'b0;
    {m_f_d1, m_f_d2, m_f_sv, m_f_op, m_f_ss} = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    acc[0] = 1'b0; acc[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_rv = '0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          exp_rv[m_owner] = 1'b1;
          held_res[m_owner] = m_fres;
          held_zero[m_owner] = m_fzero;
        end
      end
      chk("rnd_resp_valid", {resp1_valid, resp0_valid}, exp_rv);
      chk("rnd_resp0", {resp0_result, resp0_zero}, {held_res[0], held_zero[0]});
      chk("rnd_resp1", {resp1_result, resp1_zero}, {held_res[1], held_zero[1]});
      chk("rnd_busy", busy, (m_busy != 0));
      if (m_busy != 0)
        chk("rnd_alu_hold", {alu_d1, alu_d2, alu_sel, alu_ss, alu_sv},
            {m_f_d1, m_f_d2, m_f_op, m_f_ss, m_f_sv});
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          pend[p] = 1'b0;
          acc[p] = 1'b0;
          drop_req(p);
        end
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          set_req(p, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 9)));
          pend[p] = 1'b1;
        end
      end
      #1;
      idle = (m_busy == 0);
      e_r0 = idle && pend[0] && (!pend[1] || m_pref == 0);
      e_r1 = idle && pend[1] && (!pend[0] || m_pref == 1);
      chk("rnd_ready", {ready1, ready0}, {e_r1, e_r0});
      if (e_r0 || e_r1) begin
        m_owner = e_r1 ? 1 : 0;
        acc[m_owner] = 1'b1;
        m_pref = 1 - m_owner;
        m_busy = LAT + 1;
        m_f_d1 = req_d1[m_owner];
        m_f_d2 = req_d2[m_owner];
        m_f_op = req_op[m_owner];
        m_f_ss = req_ss[m_owner];
        m_f_sv = req_sv[m_owner];
        m_fres = alu_model(m_f_op, m_f_d1, m_f_d2, m_f_ss, m_f_sv);
        m_fzero = (m_f_op == OP_ADD) && (m_fres == 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
